// File: rtl/otp_xor_gate_pkg.sv
// Shared defaults and width helpers for the one-time-pad XOR unit.
package otp_xor_pkg;

  localparam int DEF_KEY_W   = 32;
  localparam int DEF_GROUP_W = 8;

  // Bits needed for a counter that must be able to hold the value g.
  function automatic int cnt_width(input int g);
    return (g < 1) ? 1 : $clog2(g + 1);
  endfunction

  // Bits needed to index a register of width w.
  function automatic int ptr_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/otp_xor_gate_if.sv
// Bit-stream, key-control and group-output signals of the OTP XOR unit.
// Handshake: a bit is taken on a rising edge where in_valid=1 and neither
// key_load nor flush is high; there is no back-pressure (the unit is always
// ready). out_valid and group_valid are single-cycle pulses with no ready.
interface otp_xor_gate_if
  import otp_xor_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int GROUP_W = DEF_GROUP_W
);

  logic                           a;
  logic                           b;
  logic                           in_valid;
  logic                           use_key;
  logic                           key_load;
  logic [KEY_W-1:0]               key_in;
  logic                           flush;
  logic                           out_comb;
  logic                           out;
  logic                           out_valid;
  logic [GROUP_W-1:0]             group_data;
  logic                           group_valid;
  logic [ptr_width(KEY_W)-1:0]    dbg_key_ptr;
  logic [cnt_width(GROUP_W)-1:0]  dbg_bit_cnt;

  modport master (
    output a, b, in_valid, use_key, key_load, key_in, flush,
    input  out_comb, out, out_valid, group_data, group_valid,
    input  dbg_key_ptr, dbg_bit_cnt
  );

  modport slave (
    input  a, b, in_valid, use_key, key_load, key_in, flush,
    output out_comb, out, out_valid, group_data, group_valid,
    output dbg_key_ptr, dbg_bit_cnt
  );

endinterface

// File: rtl/otp_xor_gate_xor_bit.sv
// Single-bit XOR core: the whole cipher is this gate applied bit by bit.
module xor_bit (
  input  logic a,
  input  logic b,
  output logic y
);

  // Pure combinational gate.
  always_comb begin
    y = a ^ b;
  end

endmodule

// File: rtl/otp_xor_gate.sv
// Bit-serial one-time-pad XOR cipher. Each accepted bit is XORed with a key
// bit (port b or the wrapping internal key register), registered, and packed
// MSB-first into GROUP_W-bit groups. Encrypt and decrypt are identical.
module otp_xor_gate
  import otp_xor_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int GROUP_W = DEF_GROUP_W
) (
  input  logic              clk,
  input  logic              rst,
  otp_xor_gate_if.slave     bus
);

  localparam int PTR_W = ptr_width(KEY_W);
  localparam int CNT_W = cnt_width(GROUP_W);
  localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUP_W - 1);

  logic [KEY_W-1:0]   key_reg;
  logic [PTR_W-1:0]   key_ptr;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GROUP_W-1:0] shift_reg;
  logic [GROUP_W-1:0] group_q;
  logic               group_valid_q;
  logic               out_q;
  logic               out_valid_q;

  logic               key_bit;
  logic               res_bit;
  logic               comb_y;
  logic               accept;
  logic [GROUP_W-1:0] shift_next;

  // Pure gate on the raw ports, no clock or reset involvement.
  xor_bit u_comb_xor (
    .a (bus.a),
    .b (bus.b),
    .y (comb_y)
  );

  // Datapath gate: data bit against the selected key bit.
  xor_bit u_dp_xor (
    .a (bus.a),
    .b (key_bit),
    .y (res_bit)
  );

  // Key-bit selection, accept qualification and next shift value.
  always_comb begin
    key_bit    = bus.use_key ? key_reg[key_ptr] : bus.b;
    accept     = bus.in_valid & ~bus.key_load & ~bus.flush;
    shift_next = {shift_reg[GROUP_W-2:0], res_bit};
  end

  // Key register and wrapping MSB-first key pointer; load and flush rewind.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg <= '0;
      key_ptr <= PTR_TOP;
    end else begin
      if (bus.key_load) begin
        key_reg <= bus.key_in;
      end
      if (bus.key_load || bus.flush) begin
        key_ptr <= PTR_TOP;
      end else if (accept && bus.use_key) begin
        key_ptr <= (key_ptr == '0) ? PTR_TOP : key_ptr - 1'b1;
      end
    end
  end

  // Result bit register, group packing and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      group_q       <= '0;
      group_valid_q <= 1'b0;
    end else begin
      out_valid_q   <= 1'b0;
      group_valid_q <= 1'b0;
      if (bus.flush) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (accept) begin
        out_q       <= res_bit;
        out_valid_q <= 1'b1;
        shift_reg   <= shift_next;
        if (bit_cnt == CNT_LAST) begin
          group_q       <= shift_next;
          group_valid_q <= 1'b1;
          bit_cnt       <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out_comb    = comb_y;
  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.group_data  = group_q;
  assign bus.group_valid = group_valid_q;
  assign bus.dbg_key_ptr = key_ptr;
  assign bus.dbg_bit_cnt = bit_cnt;

endmodule

// File: tb/tb_otp_xor_gate.sv
// Randomized and directed bench for otp_xor_gate against a behavioural model.
module tb_otp_xor_gate;
  import otp_xor_pkg::*;

  localparam int KEY_W   = 32;
  localparam int GROUP_W = 8;

  logic clk;
  logic rst;

  otp_xor_gate_if #(.KEY_W(KEY_W), .GROUP_W(GROUP_W)) bus ();

  otp_xor_gate #(.KEY_W(KEY_W), .GROUP_W(GROUP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [GROUP_W-1:0] exp_q[$];
  logic [GROUP_W-1:0] seen_groups[$];

  // Behavioural model state.
  logic [KEY_W-1:0]   m_key;
  int                 m_ptr;
  logic               m_bits[$];
  logic               e_out;
  logic               e_ov;
  logic [GROUP_W-1:0] e_gd;
  logic               e_gv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic a_i, input logic b_i, input logic iv,
                      input logic uk, input logic kl, input logic [KEY_W-1:0] ki,
                      input logic fl);
    logic kb;
    logic res;
    logic acc;
    logic [GROUP_W-1:0] g;
    @(negedge clk);
    rst          = r;
    bus.a        = a_i;
    bus.b        = b_i;
    bus.in_valid = iv;
    bus.use_key  = uk;
    bus.key_load = kl;
    bus.key_in   = ki;
    bus.flush    = fl;
    #1;
    check("out_comb", 64'(bus.out_comb), 64'(a_i ^ b_i));

    if (r) begin
      m_key = '0;
      m_ptr = KEY_W - 1;
      m_bits.delete();
      e_out = 1'b0;
      e_ov  = 1'b0;
      e_gd  = '0;
      e_gv  = 1'b0;
    end else begin
      e_ov = 1'b0;
      e_gv = 1'b0;
      acc  = iv && !kl && !fl;
      kb   = uk ? m_key[m_ptr] : b_i;
      if (kl) begin
        m_key = ki;
        m_ptr = KEY_W - 1;
      end
      if (fl) begin
        m_bits.delete();
        m_ptr = KEY_W - 1;
      end
      if (acc) begin
        res   = a_i ^ kb;
        e_out = res;
        e_ov  = 1'b1;
        m_bits.push_back(res);
        if (uk) m_ptr = (m_ptr + KEY_W - 1) % KEY_W;
        if (m_bits.size() == GROUP_W) begin
          g = '0;
          foreach (m_bits[i]) g = {g[GROUP_W-2:0], m_bits[i]};
          e_gd = g;
          e_gv = 1'b1;
          exp_q.push_back(g);
          m_bits.delete();
        end
      end
    end

    @(posedge clk);
    #1;
    check("out", 64'(bus.out), 64'(e_out));
    check("out_valid", 64'(bus.out_valid), 64'(e_ov));
    check("group_valid", 64'(bus.group_valid), 64'(e_gv));
    check("group_data", 64'(bus.group_data), 64'(e_gd));
    check("key_ptr", 64'(bus.dbg_key_ptr), 64'(m_ptr));
    check("bit_cnt", 64'(bus.dbg_bit_cnt), 64'(m_bits.size()));
    if (bus.group_valid === 1'b1) begin
      seen_groups.push_back(bus.group_data);
      if (exp_q.size() == 0) begin
        check("group_unexpected", 64'(bus.group_valid), 64'(0));
      end else begin
        check("group_sb", 64'(bus.group_data), 64'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] ct;
    logic [63:0] pt_exp;
    logic [7:0]  a_byte;
    logic [63:0] packed_g;
    int          n_groups;

    rst = 1'b1;
    bus.a = 0; bus.b = 0; bus.in_valid = 0; bus.use_key = 0;
    bus.key_load = 0; bus.key_in = '0; bus.flush = 0;

    // Reset state.
    do_reset();
    check("reset_out", 64'(bus.out), 64'(0));
    check("reset_gd", 64'(bus.group_data), 64'(0));
    check("reset_ptr", 64'(bus.dbg_key_ptr), 64'(KEY_W - 1));

    // Truth table through the gate and the registered path.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, i[1], i[0], 1'b1, 1'b0, 1'b0, '0, 1'b0);
      check("truth_out", 64'(bus.out), 64'(i[1] ^ i[0]));
    end

    // Decrypt "estrelas" with the internal key.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h66697665, 1'b0);
    seen_groups.delete();
    ct = 64'h031A021703051716;
    for (int i = 63; i >= 0; i--) begin
      step(1'b0, ct[i], 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      if (i == 32) check("ptr_wrap", 64'(bus.dbg_key_ptr), 64'(KEY_W - 1));
    end
    pt_exp = 64'h6573747265_6C6173;
    check("estrelas_count", 64'(seen_groups.size()), 64'(8));
    packed_g = '0;
    foreach (seen_groups[i]) packed_g = {packed_g[55:0], seen_groups[i]};
    check("estrelas_text", packed_g, pt_exp);

    // External key b=1 over 0xA5.
    seen_groups.delete();
    a_byte = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, a_byte[i], 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      check("a5_pulse_pos", 64'(bus.group_valid), 64'(i == 0));
    end
    check("a5_count", 64'(seen_groups.size()), 64'(1));
    check("a5_data", 64'(bus.group_data), 64'(8'h5A));

    // Gapped valid: idle cycles between accepted bits.
    seen_groups.delete();
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, a_byte[i], 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      idle($urandom_range(0, 3));
    end
    check("gap_data", 64'(seen_groups.size() == 1 ? seen_groups[0] : 8'h00), 64'(8'h5A));

    // Flush after 5 keyed bits, then 8 fresh bits with key restarted.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC3000000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("flush_ptr", 64'(bus.dbg_key_ptr), 64'(KEY_W - 1));
    seen_groups.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("flush_group", 64'(seen_groups.size() == 1 ? seen_groups[0] : 8'h00), 64'(8'hC3));

    // Reset mid-group.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("rst_mid_out", 64'(bus.out), 64'(0));
    check("rst_mid_cnt", 64'(bus.dbg_bit_cnt), 64'(0));

    // key_load coincident with a bit: bit dropped, new key used next.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80000000, 1'b0);
    check("kl_drop", 64'(bus.out_valid), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("kl_newkey", 64'(bus.out), 64'(1));

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 59) == 0), KEY_W'($urandom()),
           ($urandom_range(0, 79) == 0));
    end
    idle(2);
    n_groups = exp_q.size();
    check("sb_drained", 64'(n_groups), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
